// File: rtl/gps_iq_ser_reader_pkg.sv
// Shared constants and types for the GPS serial IQ accumulator reader.
// The word-order constants name the accumulator positions in the serial chain.
package gps_iq_ser_reader_pkg;

    localparam int GPS_CHANS      = 12;
    localparam int GPS_INTEG_BITS = 20;
    localparam int NACC           = 6;
    localparam int CH_BITS        = 4;

    localparam int W_IP = 0;
    localparam int W_QP = 1;
    localparam int W_IE = 2;
    localparam int W_QE = 3;
    localparam int W_IL = 4;
    localparam int W_QL = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/gps_iq_deser.sv
// MSB-first deserialiser for one accumulator word; flags the final bit and
// offers the word sign-extended to 32 bits, both as it completes and once held.
module gps_iq_deser #(
    parameter int INTEG_BITS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic        sin_i,
    output logic        word_done_o,
    output logic [31:0] word_next_o,
    output logic [31:0] word_held_o
);

    localparam int CW = (INTEG_BITS > 1) ? $clog2(INTEG_BITS) : 1;

    logic [INTEG_BITS-1:0] sr_q, sr_d, sr_shifted;
    logic [CW-1:0]         cnt_q, cnt_d;

    function automatic logic [31:0] sext(input logic [INTEG_BITS-1:0] v);
        logic [31:0] r;
        r = 32'(v);
        for (int i = INTEG_BITS; i < 32; i++) begin
            r[i] = v[INTEG_BITS-1];
        end
        return r;
    endfunction

    assign sr_shifted  = {sr_q[INTEG_BITS-2:0], sin_i};
    assign word_done_o = en_i && (cnt_q == CW'(INTEG_BITS - 1));
    assign word_next_o = sext(sr_shifted);
    assign word_held_o = sext(sr_q);

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (en_i) begin
            sr_d  = sr_shifted;
            cnt_d = word_done_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gps_iq_ser_reader.sv
// Reads one channel's serial IQ accumulator chain and hands each accumulator
// out as a sign-extended 32-bit word on a one-deep valid/ready output register.
module gps_iq_ser_reader #(
    parameter int GPS_CHANS      = gps_iq_ser_reader_pkg::GPS_CHANS,
    parameter int GPS_INTEG_BITS = gps_iq_ser_reader_pkg::GPS_INTEG_BITS,
    parameter int NACC           = gps_iq_ser_reader_pkg::NACC,
    parameter int CH_BITS        = gps_iq_ser_reader_pkg::CH_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic [CH_BITS-1:0]   ch,
    input  logic [GPS_CHANS-1:0] sin,
    input  logic [GPS_CHANS-1:0] load,
    output logic [GPS_CHANS-1:0] shift,
    output logic [31:0]          out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [1:0]           dbg_state_o
);

    import gps_iq_ser_reader_pkg::*;

    localparam int WW = (NACC > 1) ? $clog2(NACC) : 1;

    // Handshake: a word transfers on a cycle with out_valid & out_ready; while
    // out_valid=1 and out_ready=0, out_data/out_valid/out_last hold unchanged.

    state_t             state_q, state_d;
    logic [CH_BITS-1:0] ch_q, ch_d;
    logic [WW-1:0]      word_q, word_d;
    logic [31:0]        od_q, od_d;
    logic               ov_q, ov_d;
    logic               ol_q, ol_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic        word_done;
    logic [31:0] word_next, word_held;
    logic        accept, is_last, abort, load_en;
    logic [31:0] load_val;

    gps_iq_deser #(
        .INTEG_BITS (GPS_INTEG_BITS)
    ) u_deser (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (state_q == IDLE),
        .en_i        (state_q == SHIFT),
        .sin_i       (sin[ch_q]),
        .word_done_o (word_done),
        .word_next_o (word_next),
        .word_held_o (word_held)
    );

    assign accept  = ov_q && out_ready;
    assign is_last = (int'(word_q) == NACC - 1);
    // The draining word is already captured, so a reload there cannot corrupt it.
    assign abort   = (state_q != IDLE) && (state_q != DRAIN) && load[ch_q];

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        word_d   = word_q;
        od_d     = od_q;
        ov_d     = ov_q;
        ol_d     = ol_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        load_en  = 1'b0;
        load_val = word_next;

        if (accept) begin
            ov_d = 1'b0;
            ol_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                word_d = '0;
                if (go) begin
                    if (int'(ch) < GPS_CHANS) begin
                        ch_d    = ch;
                        state_d = SHIFT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (word_done) begin
                    if (!ov_q || out_ready) load_en = 1'b1;
                    else                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (accept) begin
                    load_en  = 1'b1;
                    load_val = word_held;
                end
            end
            DRAIN: begin
                if (accept && ol_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_en) begin
            od_d    = load_val;
            ov_d    = 1'b1;
            ol_d    = is_last;
            state_d = is_last ? DRAIN : SHIFT;
            if (!is_last) word_d = word_q + 1'b1;
        end

        if (abort) begin
            state_d = IDLE;
            ov_d    = 1'b0;
            ol_d    = 1'b0;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            word_q  <= '0;
            od_q    <= '0;
            ov_q    <= 1'b0;
            ol_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            word_q  <= word_d;
            od_q    <= od_d;
            ov_q    <= ov_d;
            ol_q    <= ol_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign shift       = (state_q == SHIFT) ? ({{(GPS_CHANS-1){1'b0}}, 1'b1} << ch_q) : '0;
    assign out_data    = od_q;
    assign out_valid   = ov_q;
    assign out_last    = ol_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign err         = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gps_iq_ser_reader.sv
// Bench for gps_iq_ser_reader: behavioural channel array feeding sin, and a
// scoreboard of expected sign-extended words checked as the reader emits them.
module tb_gps_iq_ser_reader;

    localparam int CHANS = 12;
    localparam int IB    = 20;
    localparam int NW    = 6;
    localparam int TOTB  = IB * NW;

    logic             clk = 1'b0;
    logic             rst;
    logic             go;
    logic [3:0]       ch;
    logic [CHANS-1:0] sin;
    logic [CHANS-1:0] load;
    logic [CHANS-1:0] shift;
    logic [31:0]      out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             busy;
    logic             done;
    logic             err;
    logic [1:0]       dbg_state;

    gps_iq_ser_reader dut (
        .clk         (clk),
        .rst         (rst),
        .go          (go),
        .ch          (ch),
        .sin         (sin),
        .load        (load),
        .shift       (shift),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    // Channel array model: parallel reload on load, MSB-first shift on shift.
    logic [TOTB-1:0] chan_sr [CHANS];
    logic [TOTB-1:0] pend    [CHANS];

    always @(posedge clk) begin
        for (int i = 0; i < CHANS; i++) begin
            if (rst && !busy)   chan_sr[i] <= '0;
            else if (load[i])   chan_sr[i] <= pend[i];
            else if (shift[i])  chan_sr[i] <= chan_sr[i] << 1;
        end
    end

    always_comb begin
        sin = '0;
        for (int i = 0; i < CHANS; i++) sin[i] = chan_sr[i][TOTB-1];
    end

    int total = 0;
    int bad   = 0;
    logic [32:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, want);
        end
    endtask

    int   shift3_cnt, other_cnt, done_cnt, err_cnt;
    logic stall_q, done_due;
    logic [31:0] hold_data;
    logic        hold_last;

    // Monitor samples mid-cycle; inputs change only just after posedge.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst) begin
            stall_q  = 1'b0;
            done_due = 1'b0;
        end else begin
            if (shift[3]) shift3_cnt++;
            if ((shift & ~12'h008) != '0) other_cnt++;
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (done_due) begin
                check("done_after_last", 32'(done), 32'd1);
                done_due = 1'b0;
            end
            if (stall_q) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", out_data, hold_data);
                check("hold_last", 32'(out_last), 32'(hold_last));
            end
            if (out_valid && out_ready) begin
                check("word_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("word_data", out_data, e[31:0]);
                    check("word_last", 32'(out_last), 32'(e[32]));
                    if (out_last) done_due = 1'b1;
                end
            end
            stall_q   = out_valid && !out_ready;
            hold_data = out_data;
            hold_last = out_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] sext20(input logic [IB-1:0] v);
        return {{(32-IB){v[IB-1]}}, v};
    endfunction

    task automatic push_words(input logic [TOTB-1:0] d, input int n);
        logic [IB-1:0] w;
        for (int k = 0; k < n; k++) begin
            w = d[TOTB-1-IB*k -: IB];
            exp_q.push_back({(k == NW-1), sext20(w)});
        end
    endtask

    task automatic preload(input int c, input logic [TOTB-1:0] d);
        pend[c] = d;
        load    = '0;
        load[c] = 1'b1;
        tick();
        load = '0;
    endtask

    task automatic start(input logic [3:0] c);
        go = 1'b1;
        ch = c;
        tick();
        go = 1'b0;
    endtask

    task automatic clear_counts();
        shift3_cnt = 0;
        other_cnt  = 0;
        done_cnt   = 0;
        err_cnt    = 0;
    endtask

    task automatic wait_done(input int budget, input bit rand_ready);
        int n0;
        n0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == n0; i++) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        out_ready = 1'b1;
        check("done_seen", 32'(done_cnt - n0), 32'd1);
        tick();
        check("busy_after_done", 32'(busy), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_shifts(input int n);
        for (int i = 0; i < 500 && shift3_cnt < n; i++) tick();
        check("shift_reach", 32'(shift3_cnt), 32'(n));
    endtask

    logic [TOTB-1:0] d_a, d_b, d_r;

    initial begin
        d_a = {20'h00001, 20'hFFFFF, 20'h7FFFF, 20'h80000, 20'h12345, 20'h00000};
        d_b = {20'hABCDE, 20'h0F0F0, 20'hF0F0F, 20'h00FFF, 20'hFFF00, 20'h55555};
        rst = 1'b1; go = 1'b0; ch = '0; load = '0; out_ready = 1'b0;
        clear_counts();
        tick(); tick();
        check("rst_shift", 32'(shift), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_outs", {25'd0, out_valid, out_last, busy, done, err, dbg_state}, 32'd0);
        rst = 1'b0;
        tick();

        // Full read of ch3 with no back-pressure.
        preload(3, d_a);
        clear_counts();
        push_words(d_a, NW);
        out_ready = 1'b1;
        start(4'd3);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_first_shift", 32'(shift), 32'h008);
        wait_done(400, 1'b0);
        check("t1_shift3", 32'(shift3_cnt), 32'(TOTB));
        check("t1_other", 32'(other_cnt), 32'd0);
        check("t1_err", 32'(err_cnt), 32'd0);

        // Back-pressure on word 0: reader fills word 1 then waits.
        preload(3, d_a);
        clear_counts();
        push_words(d_a, NW);
        out_ready = 1'b0;
        start(4'd3);
        for (int i = 0; i < 100 && !out_valid; i++) tick();
        check("t2_valid", 32'(out_valid), 32'd1);
        repeat (50) tick();
        check("t2_state_wait", 32'(dbg_state), 32'd2);
        check("t2_shift_off", 32'(shift), 32'd0);
        check("t2_shift3", 32'(shift3_cnt), 32'd40);
        check("t2_hold", out_data, 32'h00000001);
        out_ready = 1'b1;
        wait_done(400, 1'b0);
        check("t2_shift3_total", 32'(shift3_cnt), 32'(TOTB));

        // Reload of the selected channel during word 2 aborts.
        preload(3, d_a);
        clear_counts();
        push_words(d_a, 2);
        start(4'd3);
        wait_shifts(50);
        pend[3] = d_b;
        load    = 12'h008;
        tick();
        load = '0;
        check("t3_err", 32'(err), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_valid", 32'(out_valid), 32'd0);
        repeat (30) tick();
        check("t3_done_cnt", 32'(done_cnt), 32'd0);
        check("t3_err_cnt", 32'(err_cnt), 32'd1);
        check("t3_queue", 32'(exp_q.size()), 32'd0);
        clear_counts();
        push_words(d_b, NW);
        start(4'd3);
        wait_done(400, 1'b0);

        // Reload of a different channel mid-read is ignored.
        preload(3, d_a);
        clear_counts();
        push_words(d_a, NW);
        start(4'd3);
        wait_shifts(30);
        pend[5] = d_b;
        load    = 12'h020;
        tick();
        load = '0;
        wait_done(400, 1'b0);
        check("t4_err_cnt", 32'(err_cnt), 32'd0);

        // Out-of-range channel, then go while busy.
        clear_counts();
        start(4'd12);
        check("t5_err", 32'(err), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_shift", 32'(shift), 32'd0);
        preload(3, d_b);
        push_words(d_b, NW);
        start(4'd3);
        repeat (10) tick();
        start(4'd5);
        check("t5_busy_go_err", 32'(err), 32'd0);
        check("t5_busy_go_shift", 32'(shift), 32'h008);
        wait_done(400, 1'b0);
        check("t5_other", 32'(other_cnt), 32'd0);
        check("t5_err_cnt", 32'(err_cnt), 32'd1);

        // Reset mid-SHIFT, then a random-data read under random back-pressure.
        preload(3, d_a);
        clear_counts();
        push_words(d_a, 1);
        start(4'd3);
        wait_shifts(30);
        rst = 1'b1;
        tick();
        check("t6_shift", 32'(shift), 32'd0);
        check("t6_data", out_data, 32'd0);
        check("t6_outs", {25'd0, out_valid, out_last, busy, done, err, dbg_state}, 32'd0);
        rst = 1'b0;
        tick();
        check("t6_queue", 32'(exp_q.size()), 32'd0);
        for (int k = 0; k < NW; k++) d_r[TOTB-1-IB*k -: IB] = IB'($urandom_range(0, (1 << IB) - 1));
        preload(3, d_r);
        clear_counts();
        push_words(d_r, NW);
        start(4'd3);
        wait_done(2000, 1'b1);
        check("t6_shift3", 32'(shift3_cnt), 32'(TOTB));
        check("t6_done_cnt", 32'(done_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
